lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller that sits between an RV32I core and a data BRAM.
//
// Decodes one request at a time and sequences it as follows:
//   - Legal loads enable the BRAM once, then wait READ_LAT cycles.
//   - Legal stores issue a single lane-shifted, byte-masked write.
//   - Misaligned or illegal requests skip the BRAM and report an error.
//
// Ports:
//   clk, rstn                      clock; asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we, req_func3, req_addr,
//   req_wdata                      request fields
//   rsp_valid/rsp_ready, rsp_err   response handshake plus error flag
//   bram_en, bram_we, bram_addr,
//   bram_wdata                     BRAM port (word address, per-byte write enable)
//   rd_byte_mask, rd_func3         lane select and width information for the load byte reader
module lsu_ctrl #(
  parameter int READ_LAT   = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_err,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-3:0] bram_addr,
  output logic [31:0]           bram_wdata,
  output logic [3:0]            rd_byte_mask,
  output logic [2:0]            rd_func3
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  localparam logic [2:0] CNT_LAST = 3'(READ_LAT - 1);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] waddr_q, waddr_d;
  logic [2:0]            func3_q, func3_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  err_q, err_d;

  // Request decode: lane mask, lane-aligned store data, and error classification.
  logic [3:0]  dec_mask;
  logic [31:0] dec_wdata;
  logic        dec_err;
  logic [4:0]  lane_sh;

  always_comb begin
    lane_sh   = {req_addr[1:0], 3'b000};
    dec_mask  = 4'b0000;
    dec_wdata = 32'h0;
    dec_err   = 1'b0;
    case (req_func3)
      3'b000, 3'b100: begin
        dec_mask  = 4'b0001 << req_addr[1:0];
        dec_wdata = {24'h0, req_wdata[7:0]} << lane_sh;
      end
      3'b001, 3'b101: begin
        dec_mask  = 4'b0011 << req_addr[1:0];
        dec_wdata = {16'h0, req_wdata[15:0]} << lane_sh;
        dec_err   = req_addr[0];
      end
      3'b010: begin
        dec_mask  = 4'b1111;
        dec_wdata = req_wdata;
        dec_err   = (req_addr[1:0] != 2'b00);
      end
      default: dec_err = 1'b1;
    endcase
    // Unsigned widths exist only for loads; a store with func3[2] set is illegal.
    if (req_we && req_func3[2]) dec_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      waddr_q <= '0;
      func3_q <= 3'd0;
      wdata_q <= 32'h0;
      mask_q  <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    func3_d    = func3_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    err_d      = err_q;
    bram_en    = 1'b0;
    bram_we    = 4'b0000;
    bram_addr  = '0;
    bram_wdata = 32'h0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          waddr_d = req_addr[ADDR_WIDTH-1:2];
          func3_d = req_func3;
          wdata_d = dec_wdata;
          mask_d  = dec_mask;
          err_d   = dec_err;
          cnt_d   = 3'd0;
          if (dec_err)     state_d = RESP;
          else if (req_we) state_d = WR;
          else             state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Strobe only on the first wait cycle; the counter covers the BRAM latency.
        bram_en   = (cnt_q == 3'd0);
        bram_addr = waddr_q;
        if (cnt_q == CNT_LAST) state_d = RESP;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      WR: begin
        bram_en    = 1'b1;
        bram_we    = mask_q;
        bram_addr  = waddr_q;
        bram_wdata = wdata_q;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rstn so that it stays low while reset is held.
  assign req_ready    = (state_q == IDLE) && rstn;
  assign rd_byte_mask = (state_q != IDLE) ? mask_q  : 4'b0000;
  assign rd_func3     = (state_q != IDLE) ? func3_q : 3'b000;

endmodule
